// File: rtl/program_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_loader_pkg                                                    |
// | Shared types and constants for the byte-stream program loader.        |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package program_loader_pkg;

   // Parser state encoding
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERROR  = 3'd6
   } state_e;

   // Default frame start byte
   localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

   // States in which a frame is in progress and the idle watchdog runs
   function automatic logic in_frame(input state_e s);
      return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_word_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_assembler                                                        |
// | Packs payload bytes little-endian into 32-bit words, keeps the byte   |
// | lane index and the running XOR of all payload bytes.                  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module word_assembler (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_done_o,
   output logic [7:0]  xor_o
);

   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [23:0] lanes_q, lanes_d;
   logic [7:0]  xor_q, xor_d;

   // Lane fill, byte index advance and checksum accumulation
   always_comb begin
      byte_idx_d = byte_idx_q;
      lanes_d    = lanes_q;
      xor_d      = xor_q;
      if (clear_i) begin
         byte_idx_d = 2'd0;
         lanes_d    = 24'd0;
         xor_d      = 8'd0;
      end else if (byte_valid_i) begin
         byte_idx_d = byte_idx_q + 2'd1;
         xor_d      = xor_q ^ byte_i;
         case (byte_idx_q)
            2'd0:    lanes_d[7:0]   = byte_i;
            2'd1:    lanes_d[15:8]  = byte_i;
            2'd2:    lanes_d[23:16] = byte_i;
            default: lanes_d        = lanes_q;
         endcase
      end
   end

   // Assembler state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         byte_idx_q <= 2'd0;
         lanes_q    <= 24'd0;
         xor_q      <= 8'd0;
      end else begin
         byte_idx_q <= byte_idx_d;
         lanes_q    <= lanes_d;
         xor_q      <= xor_d;
      end
   end

   // The top lane is the byte on the bus, so the word is complete on the accepting edge
   assign word_o      = {byte_i, lanes_q};
   assign word_done_o = byte_valid_i && !clear_i && (byte_idx_q == 2'd3);
   assign xor_o       = xor_q;

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_loader                                                        |
// | Parses MAGIC/LEN/payload/CSUM byte frames, writes 32-bit words into   |
// | program memory and holds the CPU in reset until an image verifies.    |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module program_loader
   import program_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 1024,
   parameter logic [7:0]  MAGIC      = DEFAULT_MAGIC
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [7:0]            in_data_i,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   output logic                  cpu_reset_o,
   output logic                  done_o,
   output logic                  error_o
);

   // Word index is one bit wider so a full-capacity image never wraps
   localparam int unsigned IDX_W    = ADDR_WIDTH + 1;
   localparam int unsigned IDLE_W   = $clog2(TIMEOUT + 1);
   localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

   state_e                  state_q, state_d;
   logic                    in_ready_q;
   logic [15:0]             len_q, len_d;
   logic [IDX_W-1:0]        word_idx_q, word_idx_d;
   logic [IDLE_W-1:0]       idle_q, idle_d;
   logic                    mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]             mem_wdata_q, mem_wdata_d;

   logic                    w_xfer;
   logic                    w_start;
   logic                    w_data_byte;
   logic                    w_word_done;
   logic [31:0]             w_word;
   logic [7:0]              w_xor;
   logic [15:0]             w_len_new;
   logic                    w_len_bad;
   logic                    w_last_word;

   assign w_xfer      = in_valid_i && in_ready_q;
   // MAGIC only starts a frame where the parser is not inside one
   assign w_start     = w_xfer && (in_data_i == MAGIC) &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
   assign w_data_byte = w_xfer && (state_q == ST_DATA);
   assign w_len_new   = {in_data_i, len_q[7:0]};
   assign w_len_bad   = (w_len_new == 16'd0) || (32'(w_len_new) > CAPACITY);
   assign w_last_word = (32'(word_idx_q) + 32'd1) == 32'(len_q);

   word_assembler u_word_assembler (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (w_start),
      .byte_valid_i (w_data_byte),
      .byte_i       (in_data_i),
      .word_o       (w_word),
      .word_done_o  (w_word_done),
      .xor_o        (w_xor)
   );

   // Next-state, length check, memory write request and idle watchdog
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      word_idx_d  = word_idx_q;
      idle_d      = idle_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (w_start) begin
               state_d    = ST_LEN_LO;
               word_idx_d = '0;
            end
         end
         ST_LEN_LO: begin
            if (w_xfer) begin
               len_d[7:0] = in_data_i;
               state_d    = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (w_xfer) begin
               len_d[15:8] = in_data_i;
               word_idx_d  = '0;
               state_d     = w_len_bad ? ST_ERROR : ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_word_done) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
               mem_wdata_d = w_word;
               word_idx_d  = word_idx_q + IDX_W'(1);
               if (w_last_word) begin
                  state_d = ST_CSUM;
               end
            end
         end
         ST_CSUM: begin
            if (w_xfer) begin
               state_d = (in_data_i == w_xor) ? ST_DONE : ST_ERROR;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A transfer always clears the watchdog, so it wins over an expiring count
      if (in_frame(state_q)) begin
         if (w_xfer) begin
            idle_d = '0;
         end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            idle_d  = '0;
            state_d = ST_ERROR;
         end else begin
            idle_d = idle_q + IDLE_W'(1);
         end
      end else begin
         idle_d = '0;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         len_q       <= 16'd0;
         word_idx_q  <= '0;
         idle_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         word_idx_q  <= word_idx_d;
         idle_q      <= idle_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Ready comes up one clock after reset release and stays up
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         in_ready_q <= 1'b0;
      end else begin
         in_ready_q <= 1'b1;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign done_o      = (state_q == ST_DONE);
   assign error_o     = (state_q == ST_ERROR);
   assign cpu_reset_o = (state_q != ST_DONE);

endmodule
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
Byte-stream program loader. It is the write side of the SoC instruction ROM that the CPU fetches from. It parses a framed byte stream (magic, word count, little-endian instruction words, XOR checksum) and writes each assembled 32-bit word into program memory through a single write port. It holds the CPU in reset until a complete, checksum-valid image is in place.

Parameters:
ADDR_WIDTH, 8, program memory word-address width; capacity 2^ADDR_WIDTH words.
TIMEOUT, 1024, maximum idle cycles allowed between accepted bytes once a frame has started.
MAGIC, 8'hA5, frame start byte.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  byte on in_data is offered
in_ready  output  1  loader accepts the byte; transfer occurs when in_valid & in_ready at a rising edge
in_data  input  8  stream byte
mem_we  output  1  program memory write strobe, one cycle per word
mem_addr  output  ADDR_WIDTH  word address for the write
mem_wdata  output  32  instruction word, little-endian assembled
cpu_reset  output  1  active-high reset to the CPU; high except in DONE
done  output  1  image loaded and verified
error  output  1  frame rejected: bad length, checksum or timeout

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0, state=IDLE, all counters 0. in_ready is registered and rises on the first clock after reset deasserts; it then stays 1 in every state (no back-pressure).
- Frame format: MAGIC, LEN_LO, LEN_HI, then 4*LEN payload bytes (LSB first per word), then CSUM = XOR of all payload bytes only.
- States:
  - IDLE: a byte equal to MAGIC goes to LEN_LO. Any other byte is discarded.
  - LEN_LO: latch the low length byte; go to LEN_HI.
  - LEN_HI: latch the high length byte. If LEN==0 or LEN>2^ADDR_WIDTH, go to ERROR; otherwise go to DATA with word index=0 and byte index=0.
  - DATA: shift the byte into word byte lane byte_idx and update the running XOR. On the 4th byte, the next cycle has mem_we=1 for exactly one cycle, with mem_addr=word index and mem_wdata=the assembled word. Write latency is 1 cycle after the accepting edge. After the last word, go to CSUM.
  - CSUM: if the received byte equals the running XOR, go to DONE; otherwise go to ERROR.
  - DONE: done=1, cpu_reset=0. A MAGIC byte restarts the load: in the cycle after acceptance, done=0, cpu_reset=1, state=LEN_LO. Other bytes are ignored.
  - ERROR: error=1, cpu_reset=1. A MAGIC byte clears error and goes to LEN_LO. Other bytes are ignored.
- Timeout: an idle counter increments each cycle without a transfer while in LEN_LO, LEN_HI, DATA or CSUM, and clears on every transfer. Reaching TIMEOUT goes to ERROR. The counter is inactive in IDLE, DONE and ERROR.
- The running XOR and the byte/word indices clear on every MAGIC acceptance.
- A LEN of exactly 2^ADDR_WIDTH is legal; the word index must not wrap before CSUM.
- Words already written by an aborted frame remain in memory. cpu_reset stays high, so the CPU never executes a partial image.
- Asynchronous reset mid-frame immediately forces all reset values. mem_we must drop combinationally with the reset (the flop clears asynchronously).
- Simultaneous events: the timeout and a transfer in the same cycle cannot both act; a transfer wins because the counter clears on transfer.

Decomposition:
- Shared package: state encoding (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR) and the default MAGIC constant.
- One sub-module, word_assembler: byte lane shift, byte_idx, running XOR, word-complete pulse. The FSM, length check, timeout and memory port stay in program_loader.

Test Plan:
- Nominal load: stream A5 02 00 93 02 30 00 93 82 42 00 F2 -> mem_we pulses twice: addr 0 data 32'h00300293, then addr 1 data 32'h00428293. Then done=1, cpu_reset=0, error=0. Connected to the SoC, x5 reaches 3, then 7.
- Bad checksum: same stream with final byte F3 -> both writes occur, error=1, done=0, cpu_reset stays 1.
- Length bounds: A5 00 00 -> ERROR immediately after LEN_HI, with no mem_we. A5 01 01 (LEN=257, ADDR_WIDTH=8) -> ERROR, with no mem_we.
- Timeout and junk: leading junk bytes 00 FF before A5 are ignored. After A5 02 00 93, idle TIMEOUT cycles -> error=1. A new A5 clears error, and a valid frame then completes.
- Reload and reset: after DONE, A5 -> cpu_reset=1, done=0 on the next cycle. Assert reset low mid-DATA -> all outputs take reset values immediately, and in_ready returns 1 one cycle after reset is released.
